// File: rtl/montgomery_unrolled_pkg.sv
// ---------------------------------------------------------------------------
// montgomery_unrolled_pkg
//   Shared definitions for the unrolled Montgomery multiplier:
//   - MontState : FSM state encoding (IDLE / RUN / DONE)
//   - mont_rounds()    : clock rounds per operation (MOD_WIDTH / UNROLL)
//   - mont_cnt_width() : width of the round counter (at least 1 bit)
// ---------------------------------------------------------------------------
package montgomery_unrolled_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } MontState;

    function automatic int mont_rounds(input int mod_width, input int unroll);
        return mod_width / unroll;
    endfunction

    // A single-round configuration still gets a 1-bit counter so the
    // counter declaration never collapses to zero width.
    function automatic int mont_cnt_width(input int mod_width, input int unroll);
        int rounds;
        rounds = mod_width / unroll;
        return (rounds > 1) ? $clog2(rounds) : 1;
    endfunction

endpackage

// File: rtl/montgomery_unrolled_if.sv
// ---------------------------------------------------------------------------
// montgomery_unrolled_if
//   Request/response bus of the Montgomery multiplier.
//   Request  : i_valid/i_ready handshake carrying i_a, i_b, i_modulus, i_tag
//   Response : o_valid/o_ready handshake carrying o_out, o_tag
//   modport master : requester side (e.g. the RSA exponentiation controller)
//   modport slave  : multiplier side
// ---------------------------------------------------------------------------
interface montgomery_unrolled_if #(
    parameter int MOD_WIDTH = 256,
    parameter int TAG_WIDTH = 4
);
    logic                 i_valid;
    logic                 i_ready;
    logic [MOD_WIDTH-1:0] i_a;
    logic [MOD_WIDTH-1:0] i_b;
    logic [MOD_WIDTH-1:0] i_modulus;
    logic [TAG_WIDTH-1:0] i_tag;
    logic                 o_valid;
    logic                 o_ready;
    logic [MOD_WIDTH-1:0] o_out;
    logic [TAG_WIDTH-1:0] o_tag;

    modport master (
        output i_valid, i_a, i_b, i_modulus, i_tag, o_ready,
        input  i_ready, o_valid, o_out, o_tag
    );

    modport slave (
        input  i_valid, i_a, i_b, i_modulus, i_tag, o_ready,
        output i_ready, o_valid, o_out, o_tag
    );
endinterface

// File: rtl/montgomery_unrolled_step.sv
// ---------------------------------------------------------------------------
// montgomery_step
//   One combinational radix-2 Montgomery step:
//     t = acc + (bit ? b : 0); t = t + (t odd ? N : 0); acc' = t >> 1
//   Ports:
//     acc_i [MOD_WIDTH+2] running accumulator (< 2N)
//     b_i   [MOD_WIDTH]   multiplicand
//     n_i   [MOD_WIDTH]   odd modulus
//     bit_i               current multiplier bit
//     acc_o [MOD_WIDTH+2] next accumulator (< 2N)
//   Intermediate t stays below 4N, so MOD_WIDTH+2 bits never overflow.
// ---------------------------------------------------------------------------
module montgomery_step #(
    parameter int MOD_WIDTH = 256
) (
    input  logic [MOD_WIDTH+1:0] acc_i,
    input  logic [MOD_WIDTH-1:0] b_i,
    input  logic [MOD_WIDTH-1:0] n_i,
    input  logic                 bit_i,
    output logic [MOD_WIDTH+1:0] acc_o
);
    logic [MOD_WIDTH+1:0] t_add;
    logic [MOD_WIDTH+1:0] t_red;

    always_comb begin
        t_add = acc_i + (bit_i    ? {2'b00, b_i} : {(MOD_WIDTH+2){1'b0}});
        // Adding the odd modulus to an odd sum makes it even, so the
        // shift below is an exact division by two modulo N.
        t_red = t_add + (t_add[0] ? {2'b00, n_i} : {(MOD_WIDTH+2){1'b0}});
        acc_o = t_red >> 1;
    end
endmodule

// File: rtl/montgomery_unrolled.sv
// ---------------------------------------------------------------------------
// montgomery_unrolled
//   Montgomery multiplier: o_out = a * b * 2^-MOD_WIDTH mod N, retiring
//   UNROLL multiplier bits per clock (MOD_WIDTH/UNROLL rounds per op).
//   Ports:
//     clk  clock
//     rst  synchronous, active-low reset
//     bus  montgomery_unrolled_if.slave
//          request  : i_valid/i_ready, i_a, i_b, i_modulus, i_tag
//          response : o_valid/o_ready, o_out (< N), o_tag
//   A new request is taken in IDLE, or in DONE together with the pop of
//   the current result, so back-to-back ops run with no extra bubble.
// ---------------------------------------------------------------------------
module montgomery_unrolled
    import montgomery_unrolled_pkg::*;
#(
    parameter int MOD_WIDTH = 256,
    parameter int UNROLL    = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    montgomery_unrolled_if.slave    bus
);
    localparam int ROUNDS = mont_rounds(MOD_WIDTH, UNROLL);
    localparam int CNT_W  = mont_cnt_width(MOD_WIDTH, UNROLL);
    localparam int AW     = MOD_WIDTH + 2;

    if (UNROLL < 1 || UNROLL > 8 || (MOD_WIDTH % UNROLL) != 0) begin : g_param_chk
        $error("montgomery_unrolled: UNROLL must be 1..8 and divide MOD_WIDTH");
    end

    MontState             state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [AW-1:0]        acc_q;
    logic [MOD_WIDTH-1:0] a_q;      // shifted right by UNROLL each round
    logic [MOD_WIDTH-1:0] b_q;
    logic [MOD_WIDTH-1:0] n_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [MOD_WIDTH-1:0] out_q, out_d;
    logic [TAG_WIDTH-1:0] otag_q;

    logic                 last_round;
    logic                 accept;
    logic                 acc_ge_n;
    logic [UNROLL:0][AW-1:0] chain;

    assign last_round = (state_q == RUN) && (cnt_q == CNT_W'(ROUNDS - 1));
    assign accept     = bus.i_valid && bus.i_ready;

    // ---------------- unrolled step chain ----------------
    // a_q is pre-shifted, so bit j of the current round is always a_q[j].
    assign chain[0] = acc_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_step
        montgomery_step #(.MOD_WIDTH(MOD_WIDTH)) u_step (
            .acc_i (chain[j]),
            .b_i   (b_q),
            .n_i   (n_q),
            .bit_i (a_q[j]),
            .acc_o (chain[j+1])
        );
    end

    // Final conditional subtraction. The result is < N < 2^MOD_WIDTH, so the
    // low MOD_WIDTH bits of the subtraction are exact.
    always_comb begin
        acc_ge_n = chain[UNROLL] >= {2'b00, n_q};
        out_d    = acc_ge_n ? (chain[UNROLL][MOD_WIDTH-1:0] - n_q)
                            :  chain[UNROLL][MOD_WIDTH-1:0];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = RUN;
            RUN:     if (last_round)  state_d = DONE;
            DONE:    if (bus.o_ready) state_d = bus.i_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.i_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state_q)
            IDLE:    bus.i_ready = 1'b1;
            DONE: begin
                bus.o_valid = 1'b1;
                bus.i_ready = bus.o_ready;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            tag_q  <= '0;
            out_q  <= '0;
            otag_q <= '0;
        end else if (accept) begin
            a_q   <= bus.i_a;
            b_q   <= bus.i_b;
            n_q   <= bus.i_modulus;
            tag_q <= bus.i_tag;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            acc_q <= chain[UNROLL];
            a_q   <= a_q >> UNROLL;
            cnt_q <= cnt_q + CNT_W'(1);
            // Result registers only move here, so they hold through DONE.
            if (last_round) begin
                out_q  <= out_d;
                otag_q <= tag_q;
            end
        end
    end

    assign bus.o_out = out_q;
    assign bus.o_tag = otag_q;

endmodule
